// File: rtl/mul_pkg.sv
// Shared definitions for the M-extension multiply control stage:
// opcode encodings, FSM state encoding and operand signedness decode.
package mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Wide enough for MUL_LATENCY-1 with MUL_LATENCY up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns {signed_a, signed_b}; MUL is handled as unsigned since its low word is sign-agnostic.
    function automatic logic [1:0] op_signs(input logic [1:0] op);
        logic [1:0] s;
        s = 2'b00;
        case (op)
            OP_MULH:   s = 2'b11;
            OP_MULHSU: s = 2'b10;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mul_m_ctrl_sign_fix.sv
// Conditional two's-complement negate: y = neg ? -x : x (mod 2^W).
module mul_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_m_ctrl.sv
// Control stage around an external unsigned XLEN x XLEN multiplier: converts signed
// operands to magnitudes, waits MUL_LATENCY cycles, then sign-corrects and selects the word.
module mul_m_ctrl
    import mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter int XLEN        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge with in_valid & in_ready, a result
    // transfers on a rising edge with out_valid & out_ready; the producer holds valid and
    // its payload stable until that edge.

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_r;
    logic               neg_r;
    logic [2*XLEN-1:0]  prod_r;

    logic [1:0]         signs;
    logic               neg_a;
    logic               neg_b;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [2*XLEN-1:0]  p_fix;

    assign signs = op_signs(op);
    assign neg_a = signs[1] & a[XLEN-1];
    assign neg_b = signs[0] & b[XLEN-1];

    mul_sign_fix #(.W(XLEN)) u_fix_a (
        .neg (neg_a),
        .x   (a),
        .y   (mag_a)
    );

    mul_sign_fix #(.W(XLEN)) u_fix_b (
        .neg (neg_b),
        .x   (b),
        .y   (mag_b)
    );

    mul_sign_fix #(.W(2*XLEN)) u_fix_p (
        .neg (neg_r),
        .x   (prod_r),
        .y   (p_fix)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_r   <= OP_MUL;
            neg_r  <= 1'b0;
            prod_r <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a <= mag_a;
                        mul_b <= mag_b;
                        op_r  <= op;
                        neg_r <= neg_a ^ neg_b;
                        cnt   <= CNT_W'(MUL_LATENCY - 1);
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        prod_r <= mul_p;
                        state  <= ST_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= (op_r == OP_MUL) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // flush wins over a simultaneous consumer accept
                    if (flush || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_m_ctrl.sv
// Bench for mul_m_ctrl: one instance at MUL_LATENCY=1 with a combinational multiplier,
// one at MUL_LATENCY=4 with a multiplier whose output settles after 4 cycles.
module tb_mul_m_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic        iv_1, ir_1, fl_1, ov_1, or_1;
    logic [31:0] ma_1, mb_1, res_1;
    logic [63:0] mp_1;
    logic [1:0]  st_1;

    logic        iv_4, ir_4, fl_4, ov_4, or_4;
    logic [31:0] ma_4, mb_4, res_4;
    logic [63:0] mp_4;
    logic [1:0]  st_4;
    logic [63:0] pipe_4 [0:2];

    int cmp_n = 0;
    int err_n = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] ma;
        logic [31:0] mb;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    mul_m_ctrl #(.MUL_LATENCY(1), .XLEN(32)) dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_1), .in_ready(ir_1), .op(op), .a(a), .b(b),
        .flush(fl_1), .mul_a(ma_1), .mul_b(mb_1), .mul_p(mp_1), .out_valid(ov_1),
        .out_ready(or_1), .result(res_1), .dbg_state(st_1)
    );

    mul_m_ctrl #(.MUL_LATENCY(4), .XLEN(32)) dut_4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_4), .in_ready(ir_4), .op(op), .a(a), .b(b),
        .flush(fl_4), .mul_a(ma_4), .mul_b(mb_4), .mul_p(mp_4), .out_valid(ov_4),
        .out_ready(or_4), .result(res_4), .dbg_state(st_4)
    );

    assign mp_1 = {32'b0, ma_1} * {32'b0, mb_1};

    always @(posedge clk) begin
        pipe_4[0] <= {32'b0, ma_4} * {32'b0, mb_4};
        pipe_4[1] <= pipe_4[0];
        pipe_4[2] <= pipe_4[1];
    end
    assign mp_4 = pipe_4[2];

    // ISA-level definition: sign/zero-extend both operands, take the full product.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [65:0] sx, sy, p;
        sx = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'b0, x};
        sy = (o == 2'b01) ? {{34{y[31]}}, y} : {34'b0, y};
        p  = sx * sy;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic f_ir(input int s); return s ? ir_4 : ir_1; endfunction
    function automatic logic f_ov(input int s); return s ? ov_4 : ov_1; endfunction
    function automatic logic [31:0] f_res(input int s); return s ? res_4 : res_1; endfunction
    function automatic logic [31:0] f_ma(input int s); return s ? ma_4 : ma_1; endfunction
    function automatic logic [31:0] f_mb(input int s); return s ? mb_4 : mb_1; endfunction

    task automatic drv_iv(input int s, input logic v);
        if (s != 0) iv_4 = v; else iv_1 = v;
    endtask

    task automatic drv_or(input int s, input logic v);
        if (s != 0) or_4 = v; else or_1 = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance s; consumer stalls for 'hold' cycles once out_valid rises.
    task automatic do_op(input int s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, output logic [31:0] r, output logic [31:0] ma_s,
                         output logic [31:0] mb_s, output int lat);
        int n;
        @(negedge clk);
        op = o; a = x; b = y;
        drv_iv(s, 1'b1);
        n = 0;
        while (!f_ir(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        exp_q.push_back(ref_mul(o, x, y));
        @(negedge clk);
        drv_iv(s, 1'b0);
        op = 2'($urandom); a = $urandom; b = $urandom;
        ma_s = f_ma(s);
        mb_s = f_mb(s);
        lat = 1;
        while (!f_ov(s) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) check("out_valid_timeout", 32'(lat), 32'd0);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(f_ov(s)), 32'd1);
            check("hold_result", f_res(s), exp_q[0]);
            check("hold_in_ready", 32'(f_ir(s)), 32'd0);
            @(negedge clk);
        end
        drv_or(s, 1'b1);
        r = f_res(s);
        check("sb_result", r, exp_q.pop_front());
        @(negedge clk);
        drv_or(s, 1'b0);
        check("release_valid", 32'(f_ov(s)), 32'd0);
        check("release_in_ready", 32'(f_ir(s)), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, ms_a, ms_b, pick;
        int lat, seen;
        logic [1:0] ro;

        tbl[0] = '{2'b00, 32'd7,          32'd6,          32'h0000002A, 32'd7,          32'd6};
        tbl[1] = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'd1,          32'd1};
        tbl[2] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'hFFFFFFFF,   32'hFFFFFFFF};
        tbl[3] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFF,   32'hFFFFFFFF};
        tbl[4] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF};
        tbl[5] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000, 32'h80000000,   32'h80000000};
        tbl[6] = '{2'b01, 32'h00000000,   32'h80000000,   32'h00000000, 32'h00000000,   32'h80000000};

        rst_n = 1'b0; op = 2'b00; a = '0; b = '0;
        iv_1 = 0; fl_1 = 0; or_1 = 0;
        iv_4 = 0; fl_4 = 0; or_4 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(ir_1), 32'd1);
        check("rst_out_valid", 32'(ov_1), 32'd0);
        check("rst_result", res_1, 32'd0);
        check("rst_mul_a", ma_1, 32'd0);
        check("rst_mul_b", mb_1, 32'd0);
        check("rst_out_valid_l4", 32'(ov_4), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(0, tbl[i].op, tbl[i].a, tbl[i].b, 0, r, ms_a, ms_b, lat);
            check("tbl_result", r, tbl[i].r);
            check("tbl_mul_a", ms_a, tbl[i].ma);
            check("tbl_mul_b", ms_b, tbl[i].mb);
            check("tbl_latency", 32'(lat), 32'd3);
        end

        do_op(1, 2'b01, 32'hFFFFFFFD, 32'd5, 1, r, ms_a, ms_b, lat);
        check("l4_latency", 32'(lat), 32'd6);
        check("l4_result", r, 32'hFFFFFFFF);

        // Backpressure with an early second request that must wait for in_ready.
        @(negedge clk);
        op = 2'b01; a = 32'hFFFFFFFD; b = 32'd5; iv_1 = 1;
        @(negedge clk);
        iv_1 = 0;
        seen = 0;
        while (!ov_1 && seen < 20) begin @(negedge clk); seen++; end
        op = 2'b00; a = 32'd3; b = 32'd4; iv_1 = 1;
        for (int h = 0; h < 5; h++) begin
            check("bp_valid", 32'(ov_1), 32'd1);
            check("bp_result", res_1, 32'hFFFFFFFF);
            check("bp_in_ready", 32'(ir_1), 32'd0);
            @(negedge clk);
        end
        or_1 = 1;
        @(negedge clk);
        or_1 = 0;
        check("bp_release_valid", 32'(ov_1), 32'd0);
        check("bp_release_in_ready", 32'(ir_1), 32'd1);
        @(negedge clk);
        iv_1 = 0;
        seen = 0;
        while (!ov_1 && seen < 20) begin @(negedge clk); seen++; end
        check("bp_second_result", res_1, 32'd12);
        or_1 = 1;
        @(negedge clk);
        or_1 = 0;

        // Flush while the slow instance is still counting.
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd200; iv_4 = 1;
        @(negedge clk);
        iv_4 = 0;
        @(negedge clk);
        check("flush_pre_state", 32'(st_4), 32'd1);
        fl_4 = 1;
        @(negedge clk);
        fl_4 = 0;
        check("flush_state", 32'(st_4), 32'd0);
        check("flush_in_ready", 32'(ir_4), 32'd1);
        check("flush_out_valid", 32'(ov_4), 32'd0);
        seen = 0;
        for (int h = 0; h < 8; h++) begin
            if (ov_4) seen++;
            @(negedge clk);
        end
        check("flush_no_pulse", 32'(seen), 32'd0);

        // Reset asserted while the fast instance sits in FIX.
        do_op(0, 2'b00, 32'd7, 32'd6, 0, r, ms_a, ms_b, lat);
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'd9; iv_1 = 1;
        @(negedge clk);
        iv_1 = 0;
        @(negedge clk);
        check("rstfix_pre_state", 32'(st_1), 32'd2);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("rstfix_out_valid", 32'(ov_1), 32'd0);
        check("rstfix_in_ready", 32'(ir_1), 32'd1);
        check("rstfix_result", res_1, 32'd0);
        check("rstfix_mul_a", ma_1, 32'd0);
        repeat (3) @(negedge clk);
        check("rstfix_quiet", 32'(ov_1), 32'd0);

        for (int i = 0; i < 48; i++) begin
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            pick = $urandom_range(0, 7);
            case (pick)
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h0;
                3: ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            pick = $urandom_range(0, 7);
            case (pick)
                0: rb = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'h1;
                default: rb = $urandom;
            endcase
            do_op(i % 2, ro, ra, rb, $urandom_range(0, 3), r, ms_a, ms_b, lat);
            check("rand_latency", 32'(lat), (i % 2) ? 32'd6 : 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/mul_m_ctrl.md
Name: mul_m_ctrl

Overview:
- Multi-cycle control stage for the RISC-V M-extension multiply path (MUL, MULH, MULHSU, MULHU).
- Upstream of the unsigned 32x32 multiplier: converts signed operands to magnitudes and drives the multiplier inputs.
- Downstream of the same multiplier: captures its 64-bit product, applies the sign correction and selects the low or high word.
- Connects the CPU execute stage to the multiplier through valid/ready handshakes.

Parameters:
- MUL_LATENCY, 1, number of cycles the multiplier output needs to settle after its operands change (valid range 1..15).
- XLEN, 32, operand width; the product is 2*XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept a request
- op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  abort the in-flight operation
- mul_a  out  XLEN  magnitude of a, to the unsigned multiplier
- mul_b  out  XLEN  magnitude of b, to the unsigned multiplier
- mul_p  in  2*XLEN  unsigned product from the multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  selected result word

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: wait for the multiplier, counter counts MUL_LATENCY.
  - FIX: sign-correct and select.
  - DONE: out_valid=1.
- IDLE -> CALC on in_valid:
  - a is signed for MULH and MULHSU; b is signed for MULH only.
  - neg_a = signed_a & a[31]; mag_a = neg_a ? -a : a. Same for b.
  - neg_r = neg_a ^ neg_b. MUL is treated as unsigned; its low word is identical either way.
  - mag_a, mag_b, op and neg_r are registered. mul_a and mul_b come from these registers and are stable from the cycle after acceptance.
  - 0x80000000 signed gives magnitude 0x80000000 as unsigned (no overflow).
- CALC: counter loads MUL_LATENCY-1 on entry and decrements. When it reaches 0, prod_r <= mul_p and the state goes to FIX.
- FIX:
  - p = neg_r ? -prod_r : prod_r, computed mod 2^(2*XLEN); -0 = 0.
  - result <= op==00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN].
  - Go to DONE.
- DONE:
  - out_valid=1; result is held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - in_ready is 0 in every state except IDLE, so there is no overlap. Throughput is one operation per MUL_LATENCY+3 cycles with out_ready tied high.
- Latency: acceptance at cycle 0 -> out_valid first high at cycle MUL_LATENCY+2.
- flush: in any non-IDLE state, next state is IDLE, out_valid=0 and the result is discarded. flush in IDLE has no effect. flush takes priority over out_ready in DONE.
- Reset, including mid-operation:
  - State IDLE, in_ready=1, out_valid=0.
  - result, mul_a, mul_b, prod_r, counter and neg_r all set to 0.
- in_valid while not IDLE is ignored; the requester must hold the request until in_ready.
- Operands are sampled only at acceptance; later changes on a, b or op do not affect the in-flight operation.

Decomposition:
- Shared package mul_pkg:
  - op encodings OP_MUL=2'b00, OP_MULH=2'b01, OP_MULHSU=2'b10, OP_MULHU=2'b11.
  - State encoding (IDLE, CALC, FIX, DONE).
  - Function op_signs(op) returning {signed_a, signed_b}.
- One natural sub-module, mul_sign_fix: combinational conditional two's-complement negate, parameterised by width. It is instantiated for each magnitude conversion (XLEN) and for the product fix (2*XLEN).
- The multiplier stays external and is connected through mul_a, mul_b and mul_p.

Test Plan:
- MUL a=7, b=6 with a reference unsigned multiplier attached, MUL_LATENCY=1 -> result=0x0000002A, out_valid at cycle 3 after acceptance.
- a=b=0xFFFFFFFF:
  - MULH -> result=0x00000000 (product 1).
  - MULHU -> result=0xFFFFFFFE.
  - MUL -> result=0x00000001.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> mul_a=1, mul_b=0xFFFFFFFF, result=0xFFFFFFFF (product 0xFFFFFFFF_00000001).
- MULH a=b=0x80000000 -> mul_a=mul_b=0x80000000, result=0x40000000.
- MULH a=0, b=0x80000000 -> result=0 (no -0 artefact).
- Backpressure and ignored requests, MULH a=-3 (0xFFFFFFFD), b=5:
  - out_ready low for 5 cycles -> out_valid and result=0xFFFFFFFF held; in_ready stays 0.
  - A second in_valid during that window is ignored.
  - Accepted on the cycle out_ready rises.
- Abort paths:
  - flush in CALC with MUL_LATENCY=4 -> next cycle IDLE, no out_valid pulse.
  - rst_n low in FIX -> next cycle out_valid=0, in_ready=1, result=0.
